// File: rtl/ysyx_23060187_ifu.sv
// Instruction fetch unit: takes one PC, does a single AR/R read and hands inst/pc/exc to decode.
// Defining YSYX_23060187_IFU_PERF_EN adds the perf_fetch_cnt / perf_wait_cnt counters.
//
// state | meaning
// IDLE  | ready for a new PC
// REQ   | read address presented, waiting for arready
// WAIT  | waiting for read data
// HOLD  | instruction presented to decode
module ysyx_23060187_ifu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_valid,
  output logic              pc_ready,
  input  logic              flush,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [1:0]        inst_exc,
`ifdef YSYX_23060187_IFU_PERF_EN
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_wait_cnt,
`endif
  output logic              inst_valid,
  input  logic              inst_ready
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t state, state_nxt;
  logic   drop, drop_nxt;
  logic   accept;
  logic   misaligned;
  logic   take_data;

  assign pc_ready   = (state == IDLE) && !flush;
  assign arvalid    = (state == REQ);
  assign rready     = (state == WAIT);
  assign inst_valid = (state == HOLD);

  assign accept     = pc_valid && pc_ready;
  assign misaligned = (pc_in[1:0] != 2'b00);
  assign take_data  = (state == WAIT) && rvalid && !drop && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      drop  <= 1'b0;
    end else begin
      state <= state_nxt;
      drop  <= drop_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    drop_nxt  = drop;
    case (state)
      IDLE: begin
        if (accept) state_nxt = misaligned ? HOLD : REQ;
      end
      REQ: begin
        // The AR request cannot be withdrawn, so a flush here only marks the response as dead.
        if (flush)   drop_nxt  = 1'b1;
        if (arready) state_nxt = WAIT;
      end
      WAIT: begin
        if (rvalid) begin
          state_nxt = (drop || flush) ? IDLE : HOLD;
          drop_nxt  = 1'b0;
        end else if (flush) begin
          drop_nxt  = 1'b1;
        end
      end
      HOLD: begin
        if (flush || inst_ready) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        drop_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      araddr   <= '0;
      inst     <= '0;
      inst_pc  <= '0;
      inst_exc <= 2'd0;
    end else if (accept) begin
      if (misaligned) begin
        inst     <= '0;
        inst_pc  <= pc_in;
        inst_exc <= 2'd1;
      end else begin
        araddr   <= pc_in;
      end
    end else if (take_data) begin
      inst     <= (rresp != 2'b00) ? '0 : rdata;
      inst_pc  <= araddr;
      inst_exc <= (rresp != 2'b00) ? 2'd2 : 2'd0;
    end
  end

`ifdef YSYX_23060187_IFU_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= 32'd0;
      perf_wait_cnt  <= 32'd0;
    end else begin
      if (inst_valid && inst_ready && !flush) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if ((state == REQ) || (state == WAIT))  perf_wait_cnt  <= perf_wait_cnt + 32'd1;
    end
  end
`endif

endmodule
